xor_sweep_ctrl: RTL and testbench

Self-test sequencer for the two-input gate blocks (xor_gate1 and siblings). On a start pulse it drives A/B through all four input combinations in order 00, 01, 10, 11. After a programmable settle time it samples the gate output Q and compares it against a parameterised truth table. It then reports per-vector mismatches and an overall pass flag. It sits between the gate-under-test and board-level status logic (LEDs/UART) and provides on-chip exhaustive checking of any 2-input gate.

---
 rtl/xor_sweep_ctrl_if.sv | 23 ++
 rtl/xor_sweep_ctrl.sv | 104 ++++++++++
 tb/tb_xor_sweep_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/xor_sweep_ctrl_if.sv
// Signal bundle between the sweep sequencer and the gate-under-test / status logic.
// master = sequencer side, slave = gate and status side.
interface xor_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       A;
  logic       B;
  logic       Q;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;

  modport master (
    input  start, abort, Q,
    output A, B, busy, done, pass, fail_mask
  );

  modport slave (
    output start, abort, Q,
    input  A, B, busy, done, pass, fail_mask
  );
endinterface

// File: rtl/xor_sweep_ctrl.sv
// Exhaustive self-test sequencer for a 2-input gate: it drives A/B through 00..11,
// samples Q after a settle delay and checks each sample against a truth table.
module xor_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECT        = 4'b0110
) (
  input logic            clk,
  input logic            rst,
  xor_sweep_ctrl_if.master sweep
);

  localparam int unsigned   CW       = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          a_q, b_q, pass_q;
  logic [3:0]    fail_mask_q;
  logic [3:0]    mask_upd;
  logic          abort_hit;

  assign abort_hit = sweep.abort && (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sweep.start) state_nx = SETTLE;
      SETTLE:  if (cnt == '0) state_nx = SAMPLE;
      SAMPLE:  state_nx = (idx == 2'd3) ? DONE : SETTLE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort_hit) state_nx = IDLE;
  end

  // Mask including the result being sampled this cycle, so pass can be
  // registered on the same edge as the final vector and be valid alongside done.
  always_comb begin
    mask_upd      = fail_mask_q;
    mask_upd[idx] = (sweep.Q != EXPECT[idx]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
    end else if (abort_hit) begin
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sweep.start) begin
            fail_mask_q <= '0;
            pass_q      <= 1'b0;
            idx         <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            cnt         <= CNT_LOAD;
          end
        end
        SETTLE: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        SAMPLE: begin
          fail_mask_q <= mask_upd;
          if (idx == 2'd3) begin
            pass_q <= ~|mask_upd;
          end else begin
            idx        <= idx + 2'd1;
            {a_q, b_q} <= idx + 2'd1;
            cnt        <= CNT_LOAD;
          end
        end
        DONE: begin
          a_q <= 1'b0;
          b_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign sweep.A         = a_q;
  assign sweep.B         = b_q;
  assign sweep.busy      = (state == SETTLE) || (state == SAMPLE);
  assign sweep.done      = (state == DONE);
  assign sweep.pass      = pass_q;
  assign sweep.fail_mask = fail_mask_q;

endmodule

// File: tb/tb_xor_sweep_ctrl.sv
// Scoreboard bench for xor_sweep_ctrl: randomized gate truth tables, abort, re-start
// and asynchronous reset, on a default instance and a zero-settle instance.
module tb_xor_sweep_ctrl;

  localparam int unsigned S0  = 2;
  localparam int unsigned S1  = 0;
  localparam logic [3:0]  EXP = 4'b0110;

  typedef struct {
    logic [3:0] mask;
    logic       pass;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  logic [3:0] gate_tbl = 4'b0110;
  exp_t q0[$];
  exp_t q1[$];

  xor_sweep_ctrl_if bus0();
  xor_sweep_ctrl_if bus1();

  xor_sweep_ctrl #(.SETTLE_CYCLES(S0), .EXPECT(EXP)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .sweep (bus0.master)
  );

  xor_sweep_ctrl #(.SETTLE_CYCLES(S1), .EXPECT(EXP)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .sweep (bus1.master)
  );

  // Gate-under-test model: any 2-input function described by its truth table
  assign bus0.Q = gate_tbl[{bus0.A, bus0.B}];
  assign bus1.Q = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected {A,B} d cycles after the start edge for a sweep with period per
  function automatic int exp_ab(input int d, input int per);
    if (d < 0 || d > 4 * per) return 0;
    return (d / per > 3) ? 3 : d / per;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus0.done) begin
      if (q0.size() == 0) begin
        check("done0_unexpected", 1, 0);
      end else begin
        exp_t x;
        x = q0.pop_front();
        check("mask0", bus0.fail_mask, x.mask);
        check("pass0", bus0.pass, x.pass);
        check("done0_cyc", cyc, x.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus1.done) begin
      if (q1.size() == 0) begin
        check("done1_unexpected", 1, 0);
      end else begin
        exp_t x;
        x = q1.pop_front();
        check("mask1", bus1.fail_mask, x.mask);
        check("pass1", bus1.pass, x.pass);
        check("done1_cyc", cyc, x.cyc);
      end
    end
  end

  task automatic run_sweep(input logic [3:0] tbl, input bit repulse);
    int   e0;
    int   per;
    exp_t x;
    per = S0 + 2;
    @(negedge clk);
    gate_tbl   = tbl;
    bus0.start = 1'b1;
    e0         = cyc + 1;
    x.mask     = tbl ^ EXP;
    x.pass     = (tbl == EXP);
    x.cyc      = e0 + 4 * per;
    q0.push_back(x);
    for (int c = e0; c <= e0 + 4 * per + 1; c++) begin
      @(negedge clk);
      bus0.start = repulse && (cyc == e0 + 4);
      check("ab0", {bus0.A, bus0.B}, exp_ab(cyc - e0, per));
      check("busy0", bus0.busy, int'((cyc - e0) < 4 * per));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ab0"},   {bus0.A, bus0.B}, 0);
    check({tag, "_busy0"}, bus0.busy, 0);
    check({tag, "_done0"}, bus0.done, 0);
    check({tag, "_pass0"}, bus0.pass, 0);
    check({tag, "_mask0"}, bus0.fail_mask, 0);
    check({tag, "_ab1"},   {bus1.A, bus1.B}, 0);
    check({tag, "_busy1"}, bus1.busy, 0);
    check({tag, "_mask1"}, bus1.fail_mask, 0);
  endtask

  initial begin
    int         e0;
    logic [3:0] tbl;
    exp_t       x;

    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    run_sweep(4'b0110, 1'b0);
    run_sweep(4'b1000, 1'b0);

    // Zero-settle instance with Q tied low
    @(negedge clk);
    bus1.start = 1'b1;
    e0     = cyc + 1;
    x.mask = 4'b0110;
    x.pass = 1'b0;
    x.cyc  = e0 + 8;
    q1.push_back(x);
    for (int c = e0; c <= e0 + 9; c++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      check("ab1", {bus1.A, bus1.B}, exp_ab(cyc - e0, 2));
      check("busy1", bus1.busy, int'((cyc - e0) < 8));
    end

    run_sweep(4'($urandom_range(0, 15)), 1'b1);
    for (int i = 0; i < 6; i++)
      run_sweep(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    // Abort sampled at E7: vector 0 already checked, later vectors never sampled
    tbl = 4'($urandom_range(0, 15));
    @(negedge clk);
    gate_tbl   = tbl;
    bus0.start = 1'b1;
    e0         = cyc + 1;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (6) @(negedge clk);
    bus0.abort = 1'b1;
    @(negedge clk);
    bus0.abort = 1'b0;
    check("abort_ab", {bus0.A, bus0.B}, 0);
    check("abort_busy", bus0.busy, 0);
    check("abort_pass", bus0.pass, 0);
    check("abort_mask", bus0.fail_mask, (tbl ^ EXP) & 4'b0001);
    repeat (20) @(negedge clk);
    check("abort_idle", bus0.busy, 0);

    // Asynchronous reset mid-sweep with a partially failing mask
    @(negedge clk);
    gate_tbl   = 4'b1000;
    bus0.start = 1'b1;
    e0         = cyc + 1;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", bus0.busy, 1);
    check("pre_rst_mask", bus0.fail_mask, 4'b0010);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;

    run_sweep(4'b0110, 1'b0);

    repeat (5) @(negedge clk);
    check("pending0", q0.size(), 0);
    check("pending1", q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
